// File: rtl/ascon_round_engine.sv
// rtl/ascon_round_engine.sv - iterative ASCON permutation core, one round per clock
//
// ascon_linear: ASCON linear diffusion layer, purely combinational.
//   x0..x4 : substituted state words
//   y0..y4 : diffused state words
//
// ascon_round_engine: applies p^rounds to a 320-bit state, one full round
// (constant addition, S-box, diffusion) per clock.
//   clk       : system clock, rising edge
//   rst       : synchronous active-high reset
//   start     : request a permutation, sampled only in IDLE
//   rounds    : number of rounds to apply, 1..MAX_ROUNDS
//   state_in  : initial state, x0=[319:256] .. x4=[63:0]
//   state_out : live state register, same packing as state_in
//   busy      : high while rounds are being applied
//   done      : one-cycle pulse when state_out holds the final result

module ascon_linear (
  input  logic [63:0] x0,
  input  logic [63:0] x1,
  input  logic [63:0] x2,
  input  logic [63:0] x3,
  input  logic [63:0] x4,
  output logic [63:0] y0,
  output logic [63:0] y1,
  output logic [63:0] y2,
  output logic [63:0] y3,
  output logic [63:0] y4
);

  // Each word is XORed with two right-rotations of itself.
  assign y0 = x0 ^ {x0[18:0], x0[63:19]} ^ {x0[27:0], x0[63:28]};
  assign y1 = x1 ^ {x1[60:0], x1[63:61]} ^ {x1[38:0], x1[63:39]};
  assign y2 = x2 ^ {x2[0],    x2[63:1]}  ^ {x2[5:0],  x2[63:6]};
  assign y3 = x3 ^ {x3[9:0],  x3[63:10]} ^ {x3[16:0], x3[63:17]};
  assign y4 = x4 ^ {x4[6:0],  x4[63:7]}  ^ {x4[40:0], x4[63:41]};

endmodule

module ascon_round_engine #(
  parameter int MAX_ROUNDS = 12
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [3:0]   rounds,
  input  logic [319:0] state_in,
  output logic [319:0] state_out,
  output logic         busy,
  output logic         done
);

  localparam logic [3:0] MAX_R = 4'(MAX_ROUNDS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fsm_t;

  fsm_t         fsm_q;
  fsm_t         fsm_d;
  logic [319:0] state_reg;
  logic [3:0]   idx;
  logic [3:0]   remaining;
  logic         start_ok;

  function automatic logic [4:0] sbox(input logic [4:0] v);
    logic [4:0] r;
    case (v)
      5'h00: r = 5'h04; 5'h01: r = 5'h0B; 5'h02: r = 5'h1F; 5'h03: r = 5'h14;
      5'h04: r = 5'h1A; 5'h05: r = 5'h15; 5'h06: r = 5'h09; 5'h07: r = 5'h02;
      5'h08: r = 5'h1B; 5'h09: r = 5'h05; 5'h0A: r = 5'h08; 5'h0B: r = 5'h12;
      5'h0C: r = 5'h1D; 5'h0D: r = 5'h03; 5'h0E: r = 5'h06; 5'h0F: r = 5'h1C;
      5'h10: r = 5'h1E; 5'h11: r = 5'h13; 5'h12: r = 5'h07; 5'h13: r = 5'h0E;
      5'h14: r = 5'h00; 5'h15: r = 5'h0D; 5'h16: r = 5'h11; 5'h17: r = 5'h18;
      5'h18: r = 5'h10; 5'h19: r = 5'h0C; 5'h1A: r = 5'h01; 5'h1B: r = 5'h19;
      5'h1C: r = 5'h16; 5'h1D: r = 5'h0A; 5'h1E: r = 5'h0F; default: r = 5'h17;
    endcase
    return r;
  endfunction

  // Round constant: high nibble counts down while the low nibble counts up.
  logic [7:0]  rc;
  logic [63:0] c0, c1, c2, c3, c4;
  logic [63:0] s0, s1, s2, s3, s4;
  logic [63:0] l0, l1, l2, l3, l4;

  assign rc = {4'hF - idx, idx};
  assign c0 = state_reg[319:256];
  assign c1 = state_reg[255:192];
  assign c2 = state_reg[191:128] ^ {56'b0, rc};
  assign c3 = state_reg[127:64];
  assign c4 = state_reg[63:0];

  // Bit-sliced substitution: column j gathers bit j of every word, x0 as MSB.
  for (genvar j = 0; j < 64; j++) begin : g_sbox
    assign {s0[j], s1[j], s2[j], s3[j], s4[j]} = sbox({c0[j], c1[j], c2[j], c3[j], c4[j]});
  end

  ascon_linear u_linear (
    .x0 (s0), .x1 (s1), .x2 (s2), .x3 (s3), .x4 (s4),
    .y0 (l0), .y1 (l1), .y2 (l2), .y3 (l3), .y4 (l4)
  );

  assign start_ok = start && (rounds != 4'd0) && (rounds <= MAX_R);

  always_comb begin
    fsm_d = fsm_q;
    busy  = 1'b0;
    done  = 1'b0;
    case (fsm_q)
      IDLE: if (start_ok) fsm_d = RUN;
      RUN: begin
        busy = 1'b1;
        if (remaining == 4'd1) fsm_d = DONE;
      end
      DONE: begin
        done  = 1'b1;
        fsm_d = IDLE;
      end
      default: fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q     <= IDLE;
      state_reg <= '0;
      idx       <= '0;
      remaining <= '0;
    end else begin
      fsm_q <= fsm_d;
      case (fsm_q)
        IDLE: begin
          if (start_ok) begin
            state_reg <= state_in;
            idx       <= MAX_R - rounds;
            remaining <= rounds;
          end
        end
        RUN: begin
          state_reg <= {l0, l1, l2, l3, l4};
          remaining <= remaining - 4'd1;
          // Hold idx on the final round so it never leaves 0..MAX_ROUNDS-1.
          if (remaining != 4'd1) idx <= idx + 4'd1;
        end
        default: ;
      endcase
    end
  end

  assign state_out = state_reg;

endmodule
